// File: rtl/tetris_palette_fx.sv
// Palette effect sequencer: remaps the 4-bit colour index stream for the
// line-clear flash and the game-over fade. The FSM advances on frame_start;
// the remapped index is registered (1-cycle latency).
module tetris_palette_fx #(
    parameter int ROWS         = 20,
    parameter int ROW_W        = 5,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_COUNT  = 3,
    parameter int FADE_FRAMES  = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic             clear_req,
    input  logic [ROWS-1:0]  clear_rows,
    input  logic             gameover_req,
    input  logic             restart,
    input  logic             draw_valid,
    input  logic [ROW_W-1:0] draw_row,
    input  logic [3:0]       index_in,
    output logic [3:0]       index_out,
    output logic             busy,
    output logic             clear_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLASH = 2'd1;
    localparam logic [1:0] S_FADE  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int CNT_MAX = (FLASH_FRAMES > FADE_FRAMES) ? FLASH_FRAMES : FADE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PAIR_W  = $clog2(FLASH_COUNT + 1);
    localparam int MASK_W  = 1 << ROW_W;

    localparam logic [CNT_W-1:0]  FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0]  FADE_LAST  = CNT_W'(FADE_FRAMES - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST  = PAIR_W'(FLASH_COUNT - 1);

    logic [1:0]        state_q, state_d;
    logic              phase_q, phase_d;          // 1 = flash ON
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [1:0]        level_q, level_d;
    logic [ROWS-1:0]   mask_q, mask_d;
    logic [3:0]        index_q, index_d;

    // Mask widened to the full draw_row range so out-of-range rows read as 0
    logic [MASK_W-1:0] mask_ext;
    logic              row_hit;

    assign mask_ext   = MASK_W'(mask_q);
    assign row_hit    = (32'(draw_row) < ROWS) && mask_ext[draw_row];
    assign busy       = (state_q != S_IDLE);
    assign index_out  = index_q;

    // Effect FSM: request acceptance, frame counting, level/phase stepping
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        pair_cnt_d  = pair_cnt_q;
        level_d     = level_q;
        mask_d      = mask_q;
        clear_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gameover_req) begin
                    // gameover wins over a simultaneous clear
                    state_d     = S_FADE;
                    level_d     = 2'd1;
                    frame_cnt_d = '0;
                    pair_cnt_d  = '0;
                    phase_d     = 1'b0;
                    mask_d      = '0;
                end else if (clear_req) begin
                    state_d     = S_FLASH;
                    phase_d     = 1'b1;
                    frame_cnt_d = '0;
                    pair_cnt_d  = '0;
                    mask_d      = clear_rows;
                end
            end
            S_FLASH: begin
                if (gameover_req) begin
                    // abort flash without clear_done
                    state_d     = S_FADE;
                    level_d     = 2'd1;
                    frame_cnt_d = '0;
                    pair_cnt_d  = '0;
                    phase_d     = 1'b0;
                    mask_d      = '0;
                end else if (frame_start) begin
                    if (frame_cnt_q == FLASH_LAST) begin
                        frame_cnt_d = '0;
                        if (phase_q) begin
                            phase_d = 1'b0;
                        end else if (pair_cnt_q == PAIR_LAST) begin
                            state_d    = S_IDLE;
                            pair_cnt_d = '0;
                            mask_d     = '0;
                            clear_done = 1'b1;
                        end else begin
                            pair_cnt_d = pair_cnt_q + 1'b1;
                            phase_d    = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_FADE: begin
                if (restart) begin
                    state_d     = S_IDLE;
                    frame_cnt_d = '0;
                    level_d     = '0;
                end else if (frame_start) begin
                    if (frame_cnt_q == FADE_LAST) begin
                        frame_cnt_d = '0;
                        if (level_q == 2'd3) begin
                            state_d = S_HOLD;
                            level_d = '0;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (restart) begin
                    state_d     = S_IDLE;
                    frame_cnt_d = '0;
                    level_d     = '0;
                end
            end
        endcase
    end

    // Index remap from the pre-change state
    always_comb begin
        index_d = index_in;
        if (!draw_valid) begin
            index_d = 4'd0;
        end else begin
            case (state_q)
                S_FLASH: if (phase_q && row_hit && index_in != 4'd0) index_d = 4'd9;
                S_FADE: begin
                    if (index_in != 4'd0) begin
                        case (level_q)
                            2'd1:    index_d = 4'd8;
                            2'd2:    index_d = 4'd2;
                            2'd3:    index_d = 4'd13;
                            default: index_d = index_in;
                        endcase
                    end
                end
                S_HOLD:  index_d = 4'd0;
                default: index_d = index_in;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            frame_cnt_q <= '0;
            pair_cnt_q  <= '0;
            level_q     <= '0;
            mask_q      <= '0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
            level_q     <= level_d;
            mask_q      <= mask_d;
            index_q     <= index_d;
        end
    end

endmodule

// File: tb/tb_tetris_palette_fx.sv
// Scoreboard bench for tetris_palette_fx: the driver pushes expected
// index_out values, a monitor pops and compares one cycle later.
module tb_tetris_palette_fx;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        clear_req = 1'b0;
    logic [19:0] clear_rows = '0;
    logic        gameover_req = 1'b0;
    logic        restart = 1'b0;
    logic        draw_valid = 1'b0;
    logic [4:0]  draw_row = '0;
    logic [3:0]  index_in = '0;
    logic [3:0]  index_out;
    logic        busy;
    logic        clear_done;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  exq[$];
    string       nq[$];
    logic        issue = 1'b0;

    tetris_palette_fx dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .clear_req(clear_req), .clear_rows(clear_rows),
        .gameover_req(gameover_req), .restart(restart),
        .draw_valid(draw_valid), .draw_row(draw_row), .index_in(index_in),
        .index_out(index_out), .busy(busy), .clear_done(clear_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input string n, input logic dv, input logic [4:0] row,
                         input logic [3:0] idx, input logic [3:0] exp);
        draw_valid = dv;
        draw_row   = row;
        index_in   = idx;
        issue      = 1'b1;
        exq.push_back(exp);
        nq.push_back(n);
        tick;
        draw_valid = 1'b0;
        index_in   = '0;
        issue      = 1'b0;
    endtask

    task automatic frame(input logic gov, output logic cd);
        frame_start  = 1'b1;
        gameover_req = gov;
        #1;
        cd = clear_done;
        tick;
        frame_start  = 1'b0;
        gameover_req = 1'b0;
    endtask

    // Monitor: compare index_out for every cycle a pixel was issued
    initial begin : mon
        logic       had;
        logic [3:0] e;
        string      n;
        forever begin
            @(posedge Clk);
            had = issue;
            @(negedge Clk);
            if (had) begin
                if (exq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got output with no expected entry");
                end else begin
                    e = exq.pop_front();
                    n = nq.pop_front();
                    chk(n, 32'(index_out), 32'(e));
                end
            end
        end
    end

    initial begin : drv
        logic cd;
        int   cdcnt;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_index", 32'(index_out), 0);
        chk("rst_done", 32'(clear_done), 0);
        Reset_n = 1'b1;
        tick;
        tick;

        // Reset mid-flash
        clear_rows = 20'h00001;
        clear_req  = 1'b1;
        tick;
        clear_req  = 1'b0;
        draw_valid = 1'b1;
        draw_row   = 5'd0;
        index_in   = 4'd5;
        tick;
        chk("t1_pre_rst", 32'(index_out), 9);
        Reset_n = 1'b0;
        #1;
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_index", 32'(index_out), 0);
        draw_valid = 1'b0;
        index_in   = '0;
        tick;
        Reset_n = 1'b1;
        tick;
        pixel("t1_pass", 1, 0, 5, 5);

        // Flash: mask rows 0 and 19, full default duration
        clear_rows = 20'h80001;
        clear_req  = 1'b1;
        tick;
        clear_req  = 1'b0;
        pixel("t2_on_r0", 1, 0, 5, 9);
        pixel("t2_on_r7", 1, 7, 5, 5);
        pixel("t2_on_r19", 1, 19, 0, 0);
        pixel("t2_on_r19b", 1, 19, 4, 9);
        pixel("t2_on_oob", 1, 25, 5, 5);
        pixel("t6_flash_nv", 0, 0, 7, 0);
        cdcnt = 0;
        for (int i = 1; i <= 8; i++) begin
            frame(1'b0, cd);
            cdcnt += int'(cd);
        end
        pixel("t2_off_r0", 1, 0, 5, 5);
        pixel("t2_off_r7", 1, 7, 5, 5);
        pixel("t2_off_r19", 1, 19, 0, 0);
        for (int i = 9; i <= 16; i++) begin
            frame(1'b0, cd);
            cdcnt += int'(cd);
        end
        pixel("t2_on2_r0", 1, 0, 5, 9);
        for (int i = 17; i <= 47; i++) begin
            frame(1'b0, cd);
            cdcnt += int'(cd);
        end
        chk("t3_busy_pre", 32'(busy), 1);
        chk("t3_done_early", 32'(cdcnt), 0);
        frame(1'b0, cd);
        chk("t3_done_48", 32'(cd), 1);
        chk("t3_busy_after", 32'(busy), 0);
        pixel("t3_idle_r0", 1, 0, 5, 5);
        pixel("t6_idle_nv", 0, 0, 7, 0);

        // Gameover aborting a flash on its 20th frame
        clear_rows = 20'h00001;
        clear_req  = 1'b1;
        tick;
        clear_req  = 1'b0;
        cdcnt = 0;
        for (int i = 1; i <= 19; i++) begin
            frame(1'b0, cd);
            cdcnt += int'(cd);
        end
        frame(1'b1, cd);
        chk("t4_no_done", 32'(cd + 1'(cdcnt)), 0);
        pixel("t4_lvl1", 1, 3, 3, 8);
        pixel("t4_lvl1_zero", 1, 3, 0, 0);
        pixel("t6_fade_nv", 0, 3, 7, 0);
        for (int i = 0; i < 4; i++) frame(1'b0, cd);
        pixel("t4_lvl2", 1, 3, 3, 2);
        for (int i = 0; i < 4; i++) frame(1'b0, cd);
        pixel("t4_lvl3", 1, 3, 3, 13);
        for (int i = 0; i < 4; i++) frame(1'b0, cd);
        pixel("t4_hold", 1, 3, 3, 0);
        chk("t4_hold_busy", 32'(busy), 1);
        pixel("t6_hold_nv", 0, 3, 7, 0);
        restart = 1'b1;
        tick;
        restart = 1'b0;
        chk("t4_restart_busy", 32'(busy), 0);
        pixel("t4_idle", 1, 3, 3, 3);

        // Simultaneous requests; clear ignored while fading
        clear_rows   = 20'h00001;
        clear_req    = 1'b1;
        gameover_req = 1'b1;
        tick;
        clear_req    = 1'b0;
        gameover_req = 1'b0;
        pixel("t5_fade_r0", 1, 0, 5, 8);
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        pixel("t5_still_fade", 1, 0, 3, 8);
        chk("t5_busy", 32'(busy), 1);
        restart = 1'b1;
        tick;
        restart = 1'b0;
        pixel("t5_idle_r0", 1, 0, 5, 5);

        tick;
        tick;
        tick;
        chk("sb_empty", 32'(exq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
